// File: rtl/rs_pkg.sv
// Shared reservation-station types: the stored entry layout and the tag comparator used for wakeup.
package rs_pkg;

  localparam int RS_TAG_BITS     = 6;
  localparam int RS_PAYLOAD_BITS = 96;

  typedef logic [RS_TAG_BITS-1:0] rs_tag_t;

  typedef struct packed {
    logic                       valid;
    rs_tag_t                    src1_tag;
    logic                       src1_rdy;
    rs_tag_t                    src2_tag;
    logic                       src2_rdy;
    rs_tag_t                    dest_tag;
    logic [RS_PAYLOAD_BITS-1:0] payload;
  } rs_entry_t;

  function automatic logic tag_match(input rs_tag_t a, input rs_tag_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix (older[i][j]=1: entry i older than j) and the oldest-first multi-grant selector.
module rs_age_matrix #(
  parameter int NUM_ENTRIES = 16,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_ENTRIES-1:0]                 alloc,
  input  logic [NUM_ENTRIES-1:0]                 valid,
  input  logic [NUM_ENTRIES-1:0]                 ready,
  output logic [ISSUE_WIDTH-1:0][NUM_ENTRIES-1:0] grant
);

  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older;

  // Same-cycle allocations are ordered by slot index, which matches lane order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      older <= '0;
    end else begin
      for (int r = 0; r < NUM_ENTRIES; r++) begin
        for (int c = 0; c < NUM_ENTRIES; c++) begin
          if (alloc[c] && (valid[r] || (alloc[r] && r < c)))
            older[r][c] <= 1'b1;
          else if (alloc[r])
            older[r][c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    int cnt;
    grant = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cnt = 0;
      for (int j = 0; j < NUM_ENTRIES; j++)
        if (ready[j] && older[j][i]) cnt = cnt + 1;
      for (int k = 0; k < ISSUE_WIDTH; k++)
        grant[k][i] = ready[i] && (cnt == k);
    end
  end

endmodule

// File: rtl/rs_issue_queue_param.sv
// Out-of-order issue queue: multi-lane dispatch into free slots, CDB wakeup with dispatch bypass,
// oldest-ready-first multi-issue through the age matrix, and whole-queue squash on flush.
module rs_issue_queue_param
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES    = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int ISSUE_WIDTH    = 2,
  parameter int CDB_WIDTH      = 2,
  parameter int TAG_BITS       = 6,
  parameter int PAYLOAD_BITS   = 96
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [DISPATCH_WIDTH-1:0]          disp_valid,
  input  logic [DISPATCH_WIDTH*TAG_BITS-1:0] disp_src1_tag,
  input  logic [DISPATCH_WIDTH-1:0]          disp_src1_rdy,
  input  logic [DISPATCH_WIDTH*TAG_BITS-1:0] disp_src2_tag,
  input  logic [DISPATCH_WIDTH-1:0]          disp_src2_rdy,
  input  logic [DISPATCH_WIDTH*TAG_BITS-1:0] disp_dest_tag,
  input  logic [DISPATCH_WIDTH*PAYLOAD_BITS-1:0] disp_payload,
  output logic [DISPATCH_WIDTH-1:0]          disp_accept,
  input  logic [CDB_WIDTH-1:0]               cdb_valid,
  input  logic [CDB_WIDTH*TAG_BITS-1:0]      cdb_tag,
  input  logic                               issue_stall,
  output logic [ISSUE_WIDTH-1:0]             issue_valid,
  output logic [ISSUE_WIDTH*TAG_BITS-1:0]    issue_dest_tag,
  output logic [ISSUE_WIDTH*PAYLOAD_BITS-1:0] issue_payload,
  output logic [$clog2(NUM_ENTRIES):0]       free_count,
  output logic                               full,
  output logic                               empty
);

  localparam int CNT_W  = $clog2(NUM_ENTRIES) + 1;
  localparam int LANE_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  if (TAG_BITS > RS_TAG_BITS || PAYLOAD_BITS > RS_PAYLOAD_BITS) begin : g_width_check
    $error("rs_issue_queue_param: TAG_BITS/PAYLOAD_BITS exceed rs_entry_t field widths");
  end

  rs_entry_t                          ent [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]             ent_valid, ent_ready, wake1, wake2, alloc, issued;
  logic [LANE_W-1:0]                  alloc_lane [NUM_ENTRIES];
  logic [ISSUE_WIDTH-1:0][NUM_ENTRIES-1:0] grant;
  rs_tag_t                            cdb_t [CDB_WIDTH];
  rs_tag_t                            d_s1 [DISPATCH_WIDTH];
  rs_tag_t                            d_s2 [DISPATCH_WIDTH];
  rs_tag_t                            d_dst [DISPATCH_WIDTH];
  logic [RS_PAYLOAD_BITS-1:0]         d_pl [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0]          d_r1, d_r2;
  logic                               fire;

  // Unpack the flat lane buses and resolve dispatch-time readiness (map table, x0, CDB bypass).
  always_comb begin
    for (int c = 0; c < CDB_WIDTH; c++)
      cdb_t[c] = RS_TAG_BITS'(cdb_tag[c*TAG_BITS +: TAG_BITS]);
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      d_s1[l]  = RS_TAG_BITS'(disp_src1_tag[l*TAG_BITS +: TAG_BITS]);
      d_s2[l]  = RS_TAG_BITS'(disp_src2_tag[l*TAG_BITS +: TAG_BITS]);
      d_dst[l] = RS_TAG_BITS'(disp_dest_tag[l*TAG_BITS +: TAG_BITS]);
      d_pl[l]  = RS_PAYLOAD_BITS'(disp_payload[l*PAYLOAD_BITS +: PAYLOAD_BITS]);
      d_r1[l]  = disp_src1_rdy[l] || (d_s1[l] == '0);
      d_r2[l]  = disp_src2_rdy[l] || (d_s2[l] == '0);
      for (int c = 0; c < CDB_WIDTH; c++) begin
        if (cdb_valid[c] && tag_match(d_s1[l], cdb_t[c])) d_r1[l] = 1'b1;
        if (cdb_valid[c] && tag_match(d_s2[l], cdb_t[c])) d_r2[l] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      ent_valid[e] = ent[e].valid;
      ent_ready[e] = ent[e].valid && ent[e].src1_rdy && ent[e].src2_rdy;
      wake1[e]     = 1'b0;
      wake2[e]     = 1'b0;
      for (int c = 0; c < CDB_WIDTH; c++) begin
        if (cdb_valid[c] && tag_match(ent[e].src1_tag, cdb_t[c])) wake1[e] = 1'b1;
        if (cdb_valid[c] && tag_match(ent[e].src2_tag, cdb_t[c])) wake2[e] = 1'b1;
      end
    end
  end

  // Acceptance is a prefix of disp_valid bounded by the start-of-cycle free count.
  always_comb begin
    logic run;
    run = !flush;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      run            = run && disp_valid[l] && (CNT_W'(l) < free_count);
      disp_accept[l] = run;
    end
  end

  always_comb begin
    int n;
    n     = 0;
    alloc = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      alloc_lane[e] = '0;
      if (!ent[e].valid) begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
          if (n == l && disp_accept[l]) begin
            alloc[e]      = 1'b1;
            alloc_lane[e] = LANE_W'(l);
          end
        end
        n = n + 1;
      end
    end
  end

  rs_age_matrix #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_age (
    .clock (clock),
    .reset (reset),
    .alloc (alloc),
    .valid (ent_valid),
    .ready (ent_ready),
    .grant (grant)
  );

  assign fire = !issue_stall && !flush;

  always_comb begin
    rs_tag_t                    dt;
    logic [RS_PAYLOAD_BITS-1:0] pl;
    issued         = '0;
    issue_valid    = '0;
    issue_dest_tag = '0;
    issue_payload  = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      dt = '0;
      pl = '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (grant[k][e]) begin
          dt = dt | ent[e].dest_tag;
          pl = pl | ent[e].payload;
        end
      end
      issue_valid[k] = fire && (|grant[k]);
      issue_dest_tag[k*TAG_BITS +: TAG_BITS]         = TAG_BITS'(dt);
      issue_payload[k*PAYLOAD_BITS +: PAYLOAD_BITS]  = PAYLOAD_BITS'(pl);
      if (fire) issued = issued | grant[k];
    end
  end

  // Entry state: flush beats dispatch, dispatch beats issue/wakeup (only free slots are allocated).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        ent[e].valid    <= 1'b0;
        ent[e].src1_rdy <= 1'b0;
        ent[e].src2_rdy <= 1'b0;
      end
      free_count <= CNT_W'(NUM_ENTRIES);
    end else begin
      if (flush)
        free_count <= CNT_W'(NUM_ENTRIES);
      else
        free_count <= free_count + CNT_W'($countones(issued)) - CNT_W'($countones(disp_accept));
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (flush) begin
          ent[e].valid <= 1'b0;
        end else if (alloc[e]) begin
          ent[e].valid    <= 1'b1;
          ent[e].src1_tag <= d_s1[alloc_lane[e]];
          ent[e].src1_rdy <= d_r1[alloc_lane[e]];
          ent[e].src2_tag <= d_s2[alloc_lane[e]];
          ent[e].src2_rdy <= d_r2[alloc_lane[e]];
          ent[e].dest_tag <= d_dst[alloc_lane[e]];
          ent[e].payload  <= d_pl[alloc_lane[e]];
        end else begin
          if (issued[e]) ent[e].valid    <= 1'b0;
          if (wake1[e])  ent[e].src1_rdy <= 1'b1;
          if (wake2[e])  ent[e].src2_rdy <= 1'b1;
        end
      end
    end
  end

  assign full  = (free_count == '0);
  assign empty = (free_count == CNT_W'(NUM_ENTRIES));

endmodule
